// File: rtl/vu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vu_pkg
//  Purpose  : Shared vector-unit constants and the carry-save pair type used
//             by the CSA tree and the carry-propagate resolve stage.
//  Revision : 1.0 - initial release
// ============================================================================
package vu_pkg;

  // Width of the CSA tree datapath.
  localparam int c_csa_w = 48;
  // Default width of the low segment resolved in the first pipeline stage.
  localparam int c_split = 24;
  // Width of the sideband tag travelling with each transaction.
  localparam int c_tag_w = 4;

  // One carry-save vector pair as produced by the CSA tree.
  typedef struct packed {
    logic [c_csa_w-1:0] sum;
    logic [c_csa_w-1:0] carry;
  } cs_pair_t;

endpackage
`default_nettype wire

// File: rtl/cs_resolve_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cs_resolve_stage
//  Purpose  : Registered W-bit segment adder with carry-in/carry-out, a valid
//             bit and an opaque pass-through payload, advanced by an enable.
//  Revision : 1.0 - initial release
// ============================================================================
module cs_resolve_stage #(
  parameter int W  = 24,
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_valid,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic          i_cin,
  input  logic [PW-1:0] i_pass,
  output logic          o_valid,
  output logic [W-1:0]  o_sum,
  output logic          o_cout,
  output logic [PW-1:0] o_pass
);

  // Segment add is done one bit wider so the carry-out falls out naturally.
  logic [W:0] w_sum_full;
  assign w_sum_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

  // Capture the segment result, payload and valid whenever the stage advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_pass  <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_sum   <= w_sum_full[W-1:0];
      o_cout  <= w_sum_full[W];
      o_pass  <= i_pass;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cs_resolve_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cs_resolve_pipe
//  Purpose  : Resolves a carry-save (sum, carry) pair into a binary result
//             with a 2-stage pipelined carry-propagate adder split at SPLIT.
//             Valid/ready on both sides, full throughput, lossless stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module cs_resolve_pipe
  import vu_pkg::*;
#(
  parameter int BITS  = c_csa_w,
  parameter int SPLIT = c_split,
  parameter int TAG_W = c_tag_w
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [BITS-1:0]  sum_i,
  input  logic [BITS-1:0]  carry_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [BITS-1:0]  result_o,
  output logic             carry_out_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int c_hw  = BITS - SPLIT;       // high segment width
  localparam int c_pw1 = 2 * c_hw + TAG_W;   // stage-1 payload: sum_hi, carry_hi, tag
  localparam int c_pw2 = SPLIT + TAG_W;      // stage-2 payload: lo result, tag

  // Pipeline advance enables. An empty stage always advances, which is what
  // collapses bubbles; ready_o is therefore combinational from ready_i.
  logic w_en1, w_en2;
  logic w_v1;

  assign w_en2   = !valid_o || ready_i;
  assign w_en1   = !w_v1 || w_en2;
  assign ready_o = w_en1;

  // Stage 1: low segment add, high halves and tag carried forward raw.
  logic [SPLIT-1:0] w_lo1;
  logic             w_c1;
  logic [c_pw1-1:0] w_pass1;

  cs_resolve_stage #(
    .W  (SPLIT),
    .PW (c_pw1)
  ) u_stage1 (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_en    (w_en1),
    .i_valid (valid_i),
    .i_a     (sum_i[SPLIT-1:0]),
    .i_b     (carry_i[SPLIT-1:0]),
    .i_cin   (1'b0),
    .i_pass  ({sum_i[BITS-1:SPLIT], carry_i[BITS-1:SPLIT], tag_i}),
    .o_valid (w_v1),
    .o_sum   (w_lo1),
    .o_cout  (w_c1),
    .o_pass  (w_pass1)
  );

  logic [c_hw-1:0]  w_sum_hi1;
  logic [c_hw-1:0]  w_carry_hi1;
  logic [TAG_W-1:0] w_tag1;

  assign w_sum_hi1   = w_pass1[c_pw1-1 -: c_hw];
  assign w_carry_hi1 = w_pass1[TAG_W +: c_hw];
  assign w_tag1      = w_pass1[TAG_W-1:0];

  // Stage 2: high segment add with the registered inter-segment carry;
  // its registers are the block outputs.
  logic [c_hw-1:0]  w_hi2;
  logic [c_pw2-1:0] w_pass2;

  cs_resolve_stage #(
    .W  (c_hw),
    .PW (c_pw2)
  ) u_stage2 (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_en    (w_en2),
    .i_valid (w_v1),
    .i_a     (w_sum_hi1),
    .i_b     (w_carry_hi1),
    .i_cin   (w_c1),
    .i_pass  ({w_lo1, w_tag1}),
    .o_valid (valid_o),
    .o_sum   (w_hi2),
    .o_cout  (carry_out_o),
    .o_pass  (w_pass2)
  );

  assign result_o = {w_hi2, w_pass2[c_pw2-1 -: SPLIT]};
  assign tag_o    = w_pass2[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_cs_resolve_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cs_resolve_pipe
//  Purpose  : Self-checking bench for cs_resolve_pipe: directed corner cases,
//             back-pressure, mid-flight reset and randomized traffic against
//             a transaction-level reference queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cs_resolve_pipe;
  import vu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [47:0] sum_i;
  logic [47:0] carry_i;
  logic [3:0]  tag_i;
  logic        valid_o;
  logic        ready_i;
  logic [47:0] result_o;
  logic        carry_out_o;
  logic [3:0]  tag_o;

  cs_resolve_pipe #(.BITS(48), .SPLIT(24), .TAG_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sum_i       (sum_i),
    .carry_i     (carry_i),
    .tag_i       (tag_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .carry_out_o (carry_out_o),
    .tag_o       (tag_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: every accepted transaction is queued with its expected result
  // and the cycle it was accepted in; outputs must match the queue head.
  typedef struct {
    logic [47:0] res;
    logic        co;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          delivered = 0;
  logic        held_v = 1'b0;
  logic [47:0] held_res;
  logic        held_co;
  logic [3:0]  held_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // One clock of traffic: drive inputs at the falling edge, check the
  // registered outputs against the reference, then advance one cycle.
  task automatic tick(input logic v, input logic [47:0] s, input logic [47:0] c,
                      input logic [3:0] t, input logic r, output logic acc);
    logic [48:0] full;
    exp_t        e;
    logic        exp_valid;
    valid_i = v; sum_i = s; carry_i = c; tag_i = t; ready_i = r;
    #1;
    if (held_v) begin
      chk("hold_result", result_o, held_res);
      chk("hold_cout", carry_out_o, held_co);
      chk("hold_tag", tag_o, held_tag);
    end
    chk("ready_o", ready_o, (q.size() < 2) || r);
    exp_valid = (q.size() > 0) && (cyc - q[0].cyc >= 2);
    chk("valid_o", valid_o, exp_valid);
    if (valid_o && r) begin
      if (q.size() == 0) begin
        chk("unexpected_out", valid_o, 1'b0);
      end else begin
        e = q.pop_front();
        chk("out_result", result_o, e.res);
        chk("out_cout", carry_out_o, e.co);
        chk("out_tag", tag_o, e.tag);
        delivered++;
      end
    end
    acc = v && ready_o;
    if (acc) begin
      full  = {1'b0, s} + {1'b0, c};
      e.res = full[47:0];
      e.co  = full[48];
      e.tag = t;
      e.cyc = cyc;
      q.push_back(e);
    end
    held_v   = valid_o && !r;
    held_res = result_o;
    held_co  = carry_out_o;
    held_tag = tag_o;
    @(negedge clk_i);
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          k;
    int          d0;
    logic [47:0] bs [4];
    logic [47:0] bc [4];
    cs_pair_t    p;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    sum_i = '0; carry_i = '0; tag_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_result", result_o, 48'h0);
    chk("rst_cout", carry_out_o, 1'b0);
    chk("rst_tag", tag_o, 4'h0);
    chk("rst_ready", ready_o, 1'b1);

    // Carry crossing the segment boundary.
    tick(1'b1, 48'h0000_00FF_FFFF, 48'h0000_0000_0002, 4'h5, 1'b1, acc);
    chk("split_acc", acc, 1'b1);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("split_valid", valid_o, 1'b1);
    chk("split_result", result_o, 48'h0000_0100_0001);
    chk("split_cout", carry_out_o, 1'b0);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);

    // Full-width wrap.
    tick(1'b1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 4'hA, 1'b1, acc);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("wrap_valid", valid_o, 1'b1);
    chk("wrap_result", result_o, 48'h0);
    chk("wrap_cout", carry_out_o, 1'b1);
    chk("wrap_tag", tag_o, 4'hA);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);

    // Back-to-back transactions, tags 1..3.
    tick(1'b1, 48'h1234_5678_9ABC, 48'h0F0F_0F0F_0F0F, 4'h1, 1'b1, acc);
    chk("b2b_acc1", acc, 1'b1);
    tick(1'b1, 48'h8000_0000_0001, 48'h8000_0000_0001, 4'h2, 1'b1, acc);
    chk("b2b_acc2", acc, 1'b1);
    chk("b2b_v1", valid_o, 1'b1);
    chk("b2b_tag1", tag_o, 4'h1);
    tick(1'b1, 48'h0000_0000_0003, 48'h0000_0000_0005, 4'h3, 1'b1, acc);
    chk("b2b_acc3", acc, 1'b1);
    chk("b2b_tag2", tag_o, 4'h2);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("b2b_v3", valid_o, 1'b1);
    chk("b2b_tag3", tag_o, 4'h3);
    tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("b2b_idle", valid_o, 1'b0);

    // Back-pressure: four offered with the sink stalled, two fit.
    for (int i = 0; i < 4; i++) begin
      bs[i] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      bc[i] = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
    end
    d0 = delivered;
    k  = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, bs[k], bc[k], 4'(4 + k), 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    chk("bp_ready_low", ready_o, 1'b0);
    for (int i = 0; i < 10 && k < 4; i++) begin
      tick(1'b1, bs[k], bc[k], 4'(4 + k), 1'b1, acc);
      if (acc) k++;
    end
    for (int i = 0; i < 10 && q.size() > 0; i++)
      tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("bp_drained", q.size(), 0);
    chk("bp_delivered", delivered - d0, 4);

    // Reset with two transactions in flight.
    tick(1'b1, 48'h1111_1111_1111, 48'h2222_2222_2222, 4'h8, 1'b1, acc);
    tick(1'b1, 48'h3333_3333_3333, 48'h4444_4444_4444, 4'h9, 1'b0, acc);
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    q.delete();
    held_v = 1'b0;
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_result", result_o, 48'h0);
    chk("mid_rst_cout", carry_out_o, 1'b0);
    chk("mid_rst_tag", tag_o, 4'h0);
    chk("mid_rst_ready", ready_o, 1'b1);
    for (int i = 0; i < 5; i++)
      tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);

    // Randomized traffic with random stalls and corner-biased operands.
    for (int i = 0; i < 10000; i++) begin
      p.sum   = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      p.carry = {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      case ($urandom_range(0, 7))
        0: p.sum   = 48'hFFFF_FFFF_FFFF;
        1: p.carry = 48'hFFFF_FFFF_FFFF;
        2: p.sum   = 48'h0000_00FF_FFFF;
        default: ;
      endcase
      tick($urandom_range(0, 3) != 0, p.sum, p.carry, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, acc);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++)
      tick(1'b0, 48'h0, 48'h0, 4'h0, 1'b1, acc);
    chk("final_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
